// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus between the fetch sequencer, instruction memory and decode.
// The master modport is the sequencer's view.
interface fetch_ctrl_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] instr_in;
  logic [WIDTH-1:0] instr_out;
  logic             instr_valid;
  logic [WIDTH-1:0] fetch_pc;
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             irq;
  logic             irq_en;
  logic             rti;
  logic             irq_ack;
  logic             in_isr;

  modport master (
    output pc_out, instr_out, instr_valid, fetch_pc, irq_ack, in_isr,
    input  instr_in, stall, branch_taken, branch_target, irq, irq_en, rti
  );

  modport slave (
    input  pc_out, instr_out, instr_valid, fetch_pc, irq_ack, in_isr,
    output instr_in, stall, branch_taken, branch_target, irq, irq_en, rti
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, replays on stall, redirects on
// branch / interrupt entry / return-from-interrupt with zero bubbles.
module fetch_ctrl #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_PC   = 16'h0001,
  parameter logic [WIDTH-1:0] IRQ_VECTOR = 16'h0000,
  parameter logic [WIDTH-1:0] NOP_WORD   = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_ISR} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, r_fetch_pc, r_epc;
  logic             r_instr_valid, r_irq_ack;

  logic             w_rti_eff, w_irq_take;
  logic [WIDTH-1:0] w_pc_out;

  assign w_rti_eff  = bus.rti & (r_state == S_ISR);
  assign w_irq_take = bus.irq & bus.irq_en & (r_state == S_RUN) & r_instr_valid &
                      ~bus.stall & ~bus.branch_taken & ~w_rti_eff;

  always_comb begin
    w_pc_out = r_pc;
    if (rst)                                 w_pc_out = RESET_PC;
    else if (bus.branch_taken)               w_pc_out = bus.branch_target;
    else if (w_rti_eff)                      w_pc_out = r_epc;
    else if (w_irq_take)                     w_pc_out = IRQ_VECTOR;
    else if (bus.stall && r_instr_valid)     w_pc_out = r_fetch_pc;
  end

  // A branch coinciding with rti wins, so the ISR is not left.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (w_irq_take) w_state_nxt = S_ISR;
      S_ISR:   if (w_rti_eff && !bus.branch_taken) w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_fetch_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_epc         <= '0;
      r_irq_ack     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_pc_out;
      r_pc          <= w_pc_out + WIDTH'(1);
      r_instr_valid <= 1'b1;
      r_irq_ack     <= w_irq_take;
      if (w_irq_take) r_epc <= r_pc;
    end
  end

  assign bus.pc_out      = w_pc_out;
  assign bus.fetch_pc    = r_fetch_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr_out   = r_instr_valid ? bus.instr_in : NOP_WORD;
  assign bus.irq_ack     = r_irq_ack;
  assign bus.in_isr      = (r_state == S_ISR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vectors push expectations into a
// queue, a negedge monitor pops and compares them against the DUT.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.WIDTH(16)) bus ();

  fetch_ctrl #(
    .WIDTH(16), .RESET_PC(16'h0001), .IRQ_VECTOR(16'h0000), .NOP_WORD(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Memory image: 0 holds the ISR's first word, 1/2 the boot words, the rest is address-tagged.
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0000: mem_rd = 16'h0000;
      16'h0001: mem_rd = 16'h3012;
      16'h0002: mem_rd = 16'h3121;
      default:  mem_rd = 16'hF000 ^ a;
    endcase
  endfunction

  always @(posedge clk) bus.instr_in <= mem_rd(bus.pc_out);

  typedef struct {
    int          cyc;
    logic [15:0] pc_out, fpc, instr;
    logic        vld, ack, isr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL c%0d %s: got %h want %h", c, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_out",      e.cyc, bus.pc_out,   e.pc_out);
      chk("instr_valid", e.cyc, 16'(bus.instr_valid), 16'(e.vld));
      chk("fetch_pc",    e.cyc, bus.fetch_pc, e.fpc);
      chk("instr_out",   e.cyc, bus.instr_out, e.instr);
      chk("irq_ack",     e.cyc, 16'(bus.irq_ack), 16'(e.ack));
      chk("in_isr",      e.cyc, 16'(bus.in_isr),  16'(e.isr));
    end
  end

  // Drive inputs for the cycle after the next edge and record that cycle's expected outputs.
  task automatic step(input bit r, s, b, input logic [15:0] t, input bit i, ie, rt,
                      input logic [15:0] e_pc, input bit e_vld, input logic [15:0] e_fpc,
                      input bit e_ack, e_isr);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst               = r;
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
    bus.irq           = i;
    bus.irq_en        = ie;
    bus.rti           = rt;
    e.cyc    = cyc;
    e.pc_out = e_pc;
    e.vld    = e_vld;
    e.fpc    = e_fpc;
    e.instr  = e_vld ? mem_rd(e_fpc) : 16'h0000;
    e.ack    = e_ack;
    e.isr    = e_isr;
    q.push_back(e);
  endtask

  initial begin
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.irq = 0; bus.irq_en = 0; bus.rti = 0;
    //    rst stl br tgt       irq en rti  pc_out    vld fpc       ack isr
    step(0, 0, 0, 16'h0000, 0, 0, 0,   16'h0001, 0, 16'h0000, 0, 0);  // reset state
    step(0, 0, 0, 16'h0000, 0, 0, 0,   16'h0002, 1, 16'h0001, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 0, 0,   16'h0003, 1, 16'h0002, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 0, 0,   16'h0004, 1, 16'h0003, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 1, 0,   16'h0000, 1, 16'h0004, 0, 0);  // irq taken
    step(0, 0, 0, 16'h0000, 1, 1, 0,   16'h0001, 1, 16'h0000, 1, 1);  // vector, masked
    step(0, 0, 0, 16'h0000, 1, 1, 1,   16'h0005, 1, 16'h0001, 0, 1);  // rti -> epc
    step(0, 1, 0, 16'h0000, 0, 1, 0,   16'h0005, 1, 16'h0005, 0, 0);  // stall x3
    step(0, 1, 0, 16'h0000, 0, 1, 0,   16'h0005, 1, 16'h0005, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 1, 0,   16'h0005, 1, 16'h0005, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1, 0,   16'h0006, 1, 16'h0005, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1, 0,   16'h0007, 1, 16'h0006, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1, 0,   16'h0008, 1, 16'h0007, 0, 0);
    step(0, 0, 1, 16'h0010, 0, 1, 0,   16'h0010, 1, 16'h0008, 0, 0);
    step(0, 0, 1, 16'h0001, 0, 1, 0,   16'h0001, 1, 16'h0010, 0, 0);  // branch at 16
    step(0, 0, 1, 16'hFFFF, 0, 1, 0,   16'hFFFF, 1, 16'h0001, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1, 0,   16'h0000, 1, 16'hFFFF, 0, 0);  // wrap
    step(0, 0, 0, 16'h0000, 1, 1, 0,   16'h0000, 1, 16'h0000, 0, 0);  // irq again
    step(0, 0, 0, 16'h0000, 0, 1, 0,   16'h0001, 1, 16'h0000, 1, 1);
    step(0, 0, 1, 16'h0030, 1, 1, 1,   16'h0030, 1, 16'h0001, 0, 1);  // br+rti+irq
    step(0, 1, 0, 16'h0000, 0, 1, 0,   16'h0030, 1, 16'h0030, 0, 1);  // stall in ISR
    step(1, 1, 0, 16'h0000, 0, 1, 0,   16'h0001, 1, 16'h0030, 0, 1);  // reset mid-stall
    step(0, 1, 0, 16'h0000, 0, 1, 0,   16'h0001, 0, 16'h0000, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1, 0,   16'h0002, 1, 16'h0001, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1, 1,   16'h0003, 1, 16'h0002, 0, 0);  // rti in RUN ignored
    step(0, 0, 0, 16'h0000, 1, 0, 0,   16'h0004, 1, 16'h0003, 0, 0);  // irq disabled
    step(0, 0, 0, 16'h0000, 0, 0, 0,   16'h0005, 1, 16'h0004, 0, 0);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
